// File: rtl/sr_cmd_conditioner.sv
// rtl/sr_cmd_conditioner.sv - debounced, arbitrated set/clear pulse generator for an SR latch
module sr_cmd_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int CLR_PRIORITY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int PW  = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

    // bit 0 is the set path, bit 1 the clear path
    logic [1:0]     meta;
    logic [1:0]     sync;
    logic [1:0]     filt;
    logic [1:0]     filt_d;
    logic [1:0]     evt;
    logic [DBW-1:0] db_cnt [2];

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_n;
    logic          set_pend;
    logic          clr_pend;
    logic          set_pend_n;
    logic          clr_pend_n;
    logic          conflict_n;
    logic          cand_s;
    logic          cand_c;
    logic          pick_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= '0;
            sync      <= '0;
            filt      <= '0;
            filt_d    <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            meta   <= {clr_req, set_req};
            sync   <= meta;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] != filt[i]) begin
                    if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                        filt[i]   <= sync[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign evt = filt & ~filt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            set_pend <= 1'b0;
            clr_pend <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_n;
            pcnt     <= pcnt_n;
            set_pend <= set_pend_n;
            clr_pend <= clr_pend_n;
            s        <= (state_n == SET_P);
            r        <= (state_n == CLR_P);
            busy     <= (state_n != IDLE);
            conflict <= conflict_n;
        end
    end

    // GAP arbitrates like IDLE so queued work starts right after the one idle output cycle
    always_comb begin
        state_n    = state;
        pcnt_n     = pcnt;
        set_pend_n = set_pend;
        clr_pend_n = clr_pend;
        conflict_n = 1'b0;
        cand_s     = evt[0] | set_pend;
        cand_c     = evt[1] | clr_pend;
        pick_set   = cand_s & (~cand_c | (CLR_PRIORITY == 0));
        case (state)
            IDLE, GAP: begin
                state_n    = IDLE;
                conflict_n = evt[0] & evt[1];
                if (pick_set) begin
                    state_n    = SET_P;
                    pcnt_n     = PW'(PULSE_CYCLES - 1);
                    set_pend_n = 1'b0;
                    clr_pend_n = cand_c;
                end else if (cand_c) begin
                    state_n    = CLR_P;
                    pcnt_n     = PW'(PULSE_CYCLES - 1);
                    clr_pend_n = 1'b0;
                    set_pend_n = cand_s;
                end
            end
            default: begin
                set_pend_n = set_pend | evt[0];
                clr_pend_n = clr_pend | evt[1];
                if (pcnt == '0) begin
                    state_n = GAP;
                end else begin
                    pcnt_n = pcnt - 1'b1;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb/tb_sr_cmd_conditioner.sv - randomized and directed bench for sr_cmd_conditioner
module tb_sr_cmd_conditioner;
    localparam int DB   = 4;
    localparam int PC   = 2;
    localparam int CLRP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic set2 = 1'b0;
    logic clr2 = 1'b0;
    logic s, r, busy, conflict;
    logic s2, r2, busy2, conflict2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sr_cmd_conditioner #(.DB_CYCLES(DB), .PULSE_CYCLES(PC), .CLR_PRIORITY(CLRP)) u_dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .s(s), .r(r), .busy(busy), .conflict(conflict)
    );

    sr_cmd_conditioner #(.DB_CYCLES(2), .PULSE_CYCLES(30), .CLR_PRIORITY(0)) u_alt (
        .clk(clk), .rst(rst), .set_req(set2), .clr_req(clr2),
        .s(s2), .r(r2), .busy(busy2), .conflict(conflict2)
    );

    // reference model for u_dut: debounced levels plus a time-based pulse scheduler
    logic m_meta [2] = '{1'b0, 1'b0};
    logic m_sync [2] = '{1'b0, 1'b0};
    logic m_filt [2] = '{1'b0, 1'b0};
    logic m_fprev [2] = '{1'b0, 1'b0};
    int   m_run [2] = '{0, 0};
    logic m_sp = 1'b0, m_cp = 1'b0, m_conf = 1'b0;
    int   m_kind = 0;   // 0 none, 1 set pulse, 2 clear pulse
    int   m_start = 0;
    int   k = 0;
    logic e_s, e_r, e_busy, e_conf;

    task automatic model_edge(input logic rs, input logic sr_in, input logic cr_in);
        logic ev [2];
        logic raw [2];
        logic cs, cc;
        raw[0] = sr_in;
        raw[1] = cr_in;
        if (rs) begin
            for (int i = 0; i < 2; i++) begin
                m_meta[i] = 0; m_sync[i] = 0; m_filt[i] = 0; m_fprev[i] = 0; m_run[i] = 0;
            end
            m_sp = 0; m_cp = 0; m_conf = 0; m_kind = 0;
        end else begin
            for (int i = 0; i < 2; i++) ev[i] = m_filt[i] && !m_fprev[i];
            for (int i = 0; i < 2; i++) begin
                m_fprev[i] = m_filt[i];
                if (m_sync[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= DB) begin
                        m_filt[i] = m_sync[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_sync[i] = m_meta[i];
                m_meta[i] = raw[i];
            end
            m_conf = 0;
            if (m_kind == 0 || k >= m_start + PC + 1) begin
                cs = ev[0] || m_sp;
                cc = ev[1] || m_cp;
                if (cs && cc) begin
                    m_conf = ev[0] && ev[1];
                    m_start = k;
                    if (CLRP != 0) begin m_kind = 2; m_cp = 0; m_sp = 1; end
                    else begin m_kind = 1; m_sp = 0; m_cp = 1; end
                end else if (cs) begin
                    m_kind = 1; m_start = k; m_sp = 0;
                end else if (cc) begin
                    m_kind = 2; m_start = k; m_cp = 0;
                end else begin
                    m_kind = 0;
                end
            end else begin
                m_sp = m_sp || ev[0];
                m_cp = m_cp || ev[1];
            end
        end
        e_s    = (m_kind == 1) && (k < m_start + PC);
        e_r    = (m_kind == 2) && (k < m_start + PC);
        e_busy = (m_kind != 0) && (k <= m_start + PC);
        e_conf = m_conf;
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, set_req, clr_req);
        #1;
    endtask

    task automatic idle(input int n);
        set_req = 0; clr_req = 0; set2 = 0; clr2 = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        checks++;
        if ({s, r, busy, conflict} !== 4'b0000) begin
            errors++; $display("FAIL reset_main got=%b exp=0000", {s, r, busy, conflict});
        end
        checks++;
        if ({s2, r2, busy2, conflict2} !== 4'b0000) begin
            errors++; $display("FAIL reset_alt got=%b exp=0000", {s2, r2, busy2, conflict2});
        end
    endtask

    task automatic test_hold_set();
        logic [3:0] exp;
        for (int e = 0; e < 20; e++) begin
            set_req = 1;
            step();
            exp = {(e == 6 || e == 7), 1'b0, (e >= 6 && e <= 8), 1'b0};
            checks++;
            if ({s, r, busy, conflict} !== exp) begin
                errors++; $display("FAIL hold_set e=%0d got=%b exp=%b", e, {s, r, busy, conflict}, exp);
            end
        end
        idle(15);
    endtask

    task automatic test_glitch();
        for (int e = 0; e < 14; e++) begin
            clr_req = (e < 3);
            step();
            checks++;
            if ({r, busy} !== 2'b00) begin
                errors++; $display("FAIL glitch e=%0d r_busy=%b exp=00", e, {r, busy});
            end
        end
        idle(5);
    endtask

    task automatic test_tie();
        logic [3:0] exp;
        for (int e = 0; e < 14; e++) begin
            set_req = (e < 12);
            clr_req = (e < 12);
            step();
            exp = {(e == 9 || e == 10), (e == 6 || e == 7), (e >= 6 && e <= 11), (e == 6)};
            checks++;
            if ({s, r, busy, conflict} !== exp) begin
                errors++; $display("FAIL tie e=%0d got=%b exp=%b", e, {s, r, busy, conflict}, exp);
            end
        end
        idle(15);
    endtask

    task automatic test_late_clr();
        logic [3:0] exp;
        for (int e = 0; e < 14; e++) begin
            set_req = 1;
            clr_req = (e >= 1);
            step();
            exp = {(e == 6 || e == 7), (e == 9 || e == 10), (e >= 6 && e <= 11), 1'b0};
            checks++;
            if ({s, r, busy, conflict} !== exp) begin
                errors++; $display("FAIL late_clr e=%0d got=%b exp=%b", e, {s, r, busy, conflict}, exp);
            end
        end
        idle(15);
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        for (int e = 0; e < 18; e++) begin
            set_req = 1;
            rst = (e == 7);
            step();
            exp = {(e == 6 || e == 14 || e == 15), 1'b0, (e == 6 || (e >= 14 && e <= 16)), 1'b0};
            checks++;
            if ({s, r, busy, conflict} !== exp) begin
                errors++; $display("FAIL reset_mid e=%0d got=%b exp=%b", e, {s, r, busy, conflict}, exp);
            end
        end
        rst = 0;
        idle(15);
    endtask

    task automatic test_merge_alt();
        int rises = 0, high = 0, first = -1, second = -1;
        logic prev = 0;
        for (int c = 0; c < 150; c++) begin
            set2 = (c < 8) || (c >= 12 && c < 16) || (c >= 20 && c < 24) || (c >= 28 && c < 32);
            step();
            if (s2 && !prev) begin
                rises++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (s2) high++;
            prev = s2;
        end
        checks++;
        if (rises !== 2) begin errors++; $display("FAIL merge_rises got=%0d exp=2", rises); end
        checks++;
        if (first !== 4) begin errors++; $display("FAIL merge_first got=%0d exp=4", first); end
        checks++;
        if (second !== 35) begin errors++; $display("FAIL merge_second got=%0d exp=35", second); end
        checks++;
        if (high !== 60) begin errors++; $display("FAIL merge_width got=%0d exp=60", high); end
        idle(10);
    endtask

    task automatic test_priority_alt();
        int s_at = -1, r_at = -1, conf_n = 0, conf_at = -1, both = 0;
        for (int c = 0; c < 90; c++) begin
            set2 = (c < 10);
            clr2 = (c < 10);
            step();
            if (s2 && s_at < 0) s_at = c;
            if (r2 && r_at < 0) r_at = c;
            if (conflict2) begin conf_n++; conf_at = c; end
            if (s2 && r2) both++;
        end
        checks++;
        if (s_at !== 4) begin errors++; $display("FAIL prio0_s got=%0d exp=4", s_at); end
        checks++;
        if (r_at !== 35) begin errors++; $display("FAIL prio0_r got=%0d exp=35", r_at); end
        checks++;
        if (conf_n !== 1 || conf_at !== 4) begin
            errors++; $display("FAIL prio0_conflict count=%0d at=%0d exp=1 at 4", conf_n, conf_at);
        end
        checks++;
        if (both !== 0) begin errors++; $display("FAIL prio0_overlap got=%0d exp=0", both); end
        idle(5);
    endtask

    task automatic test_random();
        int hs = 0, hc = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hs == 0) begin set_req = $urandom_range(0, 1); hs = $urandom_range(1, 10); end
            if (hc == 0) begin clr_req = $urandom_range(0, 1); hc = $urandom_range(1, 10); end
            hs--; hc--;
            rst = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if ({s, r, busy, conflict} !== {e_s, e_r, e_busy, e_conf}) begin
                errors++;
                $display("FAIL random c=%0d got=%b exp=%b", c, {s, r, busy, conflict}, {e_s, e_r, e_busy, e_conf});
            end
            checks++;
            if ((s & r) !== 1'b0) begin errors++; $display("FAIL random_overlap c=%0d s=%b r=%b", c, s, r); end
        end
        rst = 0;
        idle(15);
    endtask

    initial begin
        test_reset();
        test_hold_set();
        test_glitch();
        test_tie();
        test_late_clr();
        test_reset_mid();
        test_merge_alt();
        test_priority_alt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
